// File: rtl/dll_pkg.sv
// rtl/dll_pkg.sv - shared data link layer types and sequence-number helpers
package dll_pkg;

  localparam int SEQ_W = 12;

  typedef enum logic [1:0] {
    AN_NONE = 2'b00,
    AN_ACK  = 2'b01,
    AN_NAK  = 2'b10
  } ack_nak_t;

  typedef enum logic [1:0] {
    IDLE,
    ACK_WAIT,
    SEND
  } state_t;

  // Duplicate when the TLP sits 1..half-window behind the expected number.
  function automatic logic seq_is_dup(input logic [SEQ_W-1:0] next,
                                      input logic [SEQ_W-1:0] seq);
    logic [SEQ_W-1:0] d;
    d = next - seq;
    return (d != '0) && (d <= {1'b1, {(SEQ_W-1){1'b0}}});
  endfunction

endpackage

// File: rtl/ack_latency_timer.sv
// rtl/ack_latency_timer.sv - ACK latency counter with clear, enable and expire
module ack_latency_timer #(
  parameter int ACK_LATENCY = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
  localparam logic [W-1:0] LAST = W'(ACK_LATENCY - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && (count == LAST);

endmodule

// File: rtl/ack_nak_gen.sv
// rtl/ack_nak_gen.sv - receive sequence checker and ACK/NAK DLLP scheduler
module ack_nak_gen
  import dll_pkg::*;
#(
  parameter int ACK_LATENCY  = 64,
  parameter int ACK_COALESCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tlp_valid,
  input  logic [SEQ_W-1:0] tlp_seq,
  input  logic             tlp_lcrc_ok,
  output logic             tlp_accept,
  output logic             dllp_valid,
  input  logic             dllp_ready,
  output logic [1:0]       ack_nak,
  output logic [SEQ_W-1:0] ack_seq,
  output logic [SEQ_W-1:0] next_rcv_seq
);

  localparam int PW = $clog2(ACK_COALESCE + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(ACK_COALESCE);

  state_t         state, state_nx;
  ack_nak_t       kind, load_kind;
  logic [PW-1:0]  pending, pending_nx;
  logic           nak_scheduled;
  logic           nak_latched, nak_latched_nx;
  logic           ack_latched, ack_latched_nx;
  logic           accept_now, dup_now, nak_now;
  logic           load, timer_expire;

  always_comb begin
    accept_now = tlp_valid && tlp_lcrc_ok && (tlp_seq == next_rcv_seq);
    dup_now    = tlp_valid && tlp_lcrc_ok && seq_is_dup(next_rcv_seq, tlp_seq);
    nak_now    = tlp_valid && !accept_now && !dup_now && !nak_scheduled;
  end

  always_comb begin
    state_nx       = state;
    load           = 1'b0;
    load_kind      = AN_ACK;
    pending_nx     = pending;
    nak_latched_nx = nak_latched;
    ack_latched_nx = ack_latched;
    case (state)
      IDLE, ACK_WAIT: begin
        if (nak_now) begin
          load      = 1'b1;
          load_kind = AN_NAK;
        end else if (dup_now ||
                     (state == ACK_WAIT && (timer_expire || pending == PEND_MAX))) begin
          load = 1'b1;
        end else if (accept_now) begin
          state_nx = ACK_WAIT;
        end
      end
      SEND: begin
        if (dllp_ready) begin
          if (nak_latched || nak_now) begin
            load      = 1'b1;
            load_kind = AN_NAK;
          end else if (ack_latched || dup_now) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          // The loaded payload is frozen; later events wait their turn.
          nak_latched_nx = nak_latched || nak_now;
          ack_latched_nx = ack_latched || dup_now;
        end
      end
      default: state_nx = IDLE;
    endcase

    // A NAK acknowledges everything before it, so it also retires a latched ACK.
    if (load) begin
      state_nx       = SEND;
      pending_nx     = '0;
      nak_latched_nx = 1'b0;
      ack_latched_nx = 1'b0;
    end
    if (accept_now && pending_nx != PEND_MAX) begin
      pending_nx = pending_nx + 1'b1;
    end
    if (state == SEND && dllp_ready && !load && pending_nx != '0) begin
      state_nx = ACK_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      kind          <= AN_NONE;
      pending       <= '0;
      nak_scheduled <= 1'b0;
      nak_latched   <= 1'b0;
      ack_latched   <= 1'b0;
      tlp_accept    <= 1'b0;
      next_rcv_seq  <= '0;
      ack_seq       <= '0;
    end else begin
      state       <= state_nx;
      pending     <= pending_nx;
      nak_latched <= nak_latched_nx;
      ack_latched <= ack_latched_nx;
      tlp_accept  <= accept_now;
      if (accept_now) begin
        next_rcv_seq  <= next_rcv_seq + 1'b1;
        nak_scheduled <= 1'b0;
      end else if (nak_now) begin
        nak_scheduled <= 1'b1;
      end
      if (load) begin
        kind    <= load_kind;
        ack_seq <= next_rcv_seq - 1'b1;
      end
    end
  end

  ack_latency_timer #(.ACK_LATENCY(ACK_LATENCY)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (load || state != ACK_WAIT),
    .enable (state == ACK_WAIT),
    .expire (timer_expire)
  );

  assign dllp_valid = (state == SEND);
  assign ack_nak    = dllp_valid ? kind : AN_NONE;

endmodule
